// File: rtl/tvout_pkg.sv
// tvout_pkg: shared scan-mode enum, test-pattern border and PAL default timing for the tvout path.
package tvout_pkg;
  typedef enum logic [1:0] {
    VISIBLE = 2'b00,
    BLANKED = 2'b01,
    VSYNC   = 2'b10
  } mode_t;
  localparam int TP_BORDER       = 4;
  localparam int PAL_CLK_DIV     = 5;
  localparam int PAL_H_TOTAL     = 640;
  localparam int PAL_H_VISIBLE   = 512;
  localparam int PAL_HSYNC_START = 533;
  localparam int PAL_HSYNC_END   = 580;
  localparam int PAL_V_TOTAL     = 309;
  localparam int PAL_V_VISIBLE   = 288;
  localparam int PAL_VSYNC_START = 290;
  localparam int PAL_VSYNC_END   = 292;
  localparam int PAL_FETCH_LAT   = 1;
endpackage

// File: rtl/tv_delay_line.sv
// tv_delay_line: DEPTH-stage shift register advancing on ce, synchronous clear.
module tv_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [DEPTH];
  always_ff @(posedge clk)
    if (rst) sr <= '{default: '0};
    else if (ce) begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/tv_timing_gen.sv
// tv_timing_gen: PAL-style scan/sync generator with RAM fetch realignment.
// Defining TVOUT_TESTPAT_EN adds test_en, which replaces pix_data with a box outline.
module tv_timing_gen
  import tvout_pkg::*;
#(
  parameter int CLK_DIV     = PAL_CLK_DIV,
  parameter int H_TOTAL     = PAL_H_TOTAL,
  parameter int H_VISIBLE   = PAL_H_VISIBLE,
  parameter int HSYNC_START = PAL_HSYNC_START,
  parameter int HSYNC_END   = PAL_HSYNC_END,
  parameter int V_TOTAL     = PAL_V_TOTAL,
  parameter int V_VISIBLE   = PAL_V_VISIBLE,
  parameter int VSYNC_START = PAL_VSYNC_START,
  parameter int VSYNC_END   = PAL_VSYNC_END,
  parameter int FETCH_LAT   = PAL_FETCH_LAT,
  parameter int LUMA_W      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       pix_ce,
  output logic [$clog2(H_TOTAL)-1:0] pix_x,
  output logic [$clog2(V_TOTAL)-1:0] pix_y,
  output logic                       pix_fetch,
  input  logic [LUMA_W-1:0]          pix_data,
`ifdef TVOUT_TESTPAT_EN
  input  logic                       test_en,
`endif
  output logic                       frame_start,
  output logic [LUMA_W-1:0]          vout,
  output logic                       sync_n
);
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);
  localparam int DW = $clog2(CLK_DIV);
  logic [DW-1:0] div;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic x_last, y_last, vis, vsync, hsync, raw_sync, vis_d, sync_d;
  logic [LUMA_W-1:0] luma;
  mode_t mode;
  if (!(H_VISIBLE <= HSYNC_START && HSYNC_START < HSYNC_END && HSYNC_END <= H_TOTAL &&
        V_VISIBLE < VSYNC_START && VSYNC_START < VSYNC_END && VSYNC_END < V_TOTAL &&
        CLK_DIV >= 2 && FETCH_LAT >= 1)) begin : g_bad_params
    $error("tv_timing_gen: inconsistent timing parameters");
  end
  assign pix_ce = int'(div) == CLK_DIV - 1;
  assign x_last = int'(x) == H_TOTAL - 1;
  assign y_last = int'(y) == V_TOTAL - 1;
  always_ff @(posedge clk)
    if (rst) begin
      div <= '0;
      x   <= '0;
      y   <= '0;
    end else begin
      div <= pix_ce ? '0 : div + 1'b1;
      if (pix_ce) begin
        x <= x_last ? '0 : x + 1'b1;
        if (x_last) y <= y_last ? '0 : y + 1'b1;
      end
    end
  // The broad-sync tail line only syncs during its first half
  assign vis   = int'(x) < H_VISIBLE && int'(y) < V_VISIBLE;
  assign vsync = (int'(y) >= VSYNC_START && int'(y) < VSYNC_END) ||
                 (int'(y) == VSYNC_END && int'(x) < H_TOTAL / 2);
  assign hsync = int'(x) >= HSYNC_START && int'(x) < HSYNC_END;
  assign mode  = vis ? VISIBLE : vsync ? VSYNC : BLANKED;
  assign raw_sync    = mode == VSYNC || hsync;
  assign pix_fetch   = mode == VISIBLE;
  assign pix_x       = x;
  assign pix_y       = y;
  assign frame_start = pix_ce && x == '0 && y == '0;
  tv_delay_line #(.W(2), .DEPTH(FETCH_LAT)) u_vis_sync_dly (
    .clk(clk),
    .rst(rst),
    .ce (pix_ce),
    .d  ({pix_fetch, raw_sync}),
    .q  ({vis_d, sync_d})
  );
`ifdef TVOUT_TESTPAT_EN
  logic tp_on, te_d, tp_d;
  assign tp_on = int'(x) == TP_BORDER || int'(x) == H_VISIBLE - 1 - TP_BORDER ||
                 int'(y) == TP_BORDER || int'(y) == V_VISIBLE - 1 - TP_BORDER;
  tv_delay_line #(.W(2), .DEPTH(FETCH_LAT)) u_tp_dly (
    .clk(clk),
    .rst(rst),
    .ce (pix_ce),
    .d  ({test_en, tp_on}),
    .q  ({te_d, tp_d})
  );
  assign luma = te_d ? {LUMA_W{tp_d}} : pix_data;
`else
  assign luma = pix_data;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      vout   <= '0;
      sync_n <= 1'b1;
    end else if (pix_ce) begin
      vout   <= vis_d ? luma : '0;
      sync_n <= !sync_d;
    end
endmodule
